// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache controller: FSM state encoding,
// write-policy constants and the word-index width function.
package cache_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_WBACK  = 3'd2,
      S_FILL   = 3'd3,
      S_WTHRU  = 3'd4,
      S_DONE   = 3'd5
   } state_e;

   localparam bit POLICY_WB = 1'b1;
   localparam bit POLICY_WT = 1'b0;

   // Index width never drops below one bit, even for single-word lines
   function automatic int unsigned idx_w(input int unsigned words);
      return (words <= 1) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Word index counter for line fill / write-back bursts; wraps after the
// last word of a line and flags that last word.
module cache_beat_counter
   import cache_pkg::*;
#(
   parameter  int unsigned WORDS_PER_LINE = 4,
   localparam int unsigned IW             = idx_w(WORDS_PER_LINE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_inc,
   input  logic          i_clr,
   output logic [IW-1:0] o_idx,
   output logic          o_last
);

   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_PER_LINE - 1);

   logic [IW-1:0] r_idx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_idx <= '0;
      end else if (i_clr) begin
         r_idx <= '0;
      end else if (i_inc) begin
         r_idx <= o_last ? '0 : r_idx + IW'(1);
      end
   end

   assign o_idx  = r_idx;
   assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Cache controller FSM: sequences CPU requests against the tag/data arrays
// and a handshaked next-level memory, with saturating hit/miss statistics.
module cache_ctrl_fsm
   import cache_pkg::*;
#(
   parameter  int unsigned WORDS_PER_LINE = 4,
   parameter  bit          WRITE_BACK     = POLICY_WB,
   parameter  int unsigned CNT_W          = 16,
   localparam int unsigned IW             = idx_w(WORDS_PER_LINE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic             hit,
   input  logic             dirty,
   input  logic             mem_ack,
   output logic             cRead,
   output logic             cWrite,
   output logic             tagWrite,
   output logic             dirtySet,
   output logic             rRead,
   output logic             rWrite,
   output logic             selOut,
   output logic [IW-1:0]    wordIdx,
   output logic             cpu_done,
   output logic             busy,
   output logic [CNT_W-1:0] hitCount,
   output logic [CNT_W-1:0] missCount
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic             w_inc;
   logic             w_clr;
   logic             w_last;
   logic [IW-1:0]    w_idx;
   logic             r_relookup;
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_miss_cnt;

   cache_beat_counter #(
      .WORDS_PER_LINE(WORDS_PER_LINE)
   ) u_beat (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_inc),
      .i_clr (w_clr),
      .o_idx (w_idx),
      .o_last(w_last)
   );

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_inc       = 1'b0;
      w_clr       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_clr = 1'b1;
            if (cpu_req) w_state_nxt = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (hit) begin
               if (cpu_we && !WRITE_BACK) w_state_nxt = S_WTHRU;
               else                       w_state_nxt = S_DONE;
            end else if (cpu_we && !WRITE_BACK) begin
               w_state_nxt = S_WTHRU;
            end else if (WRITE_BACK && dirty) begin
               w_state_nxt = S_WBACK;
            end else begin
               w_state_nxt = S_FILL;
            end
         end
         S_WBACK: begin
            if (mem_ack) begin
               w_inc = 1'b1;
               if (w_last) w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            if (mem_ack) begin
               w_inc = 1'b1;
               if (w_last) w_state_nxt = S_LOOKUP;
            end
         end
         S_WTHRU: begin
            if (mem_ack) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Tag write must coincide with the last fill beat so the re-lookup hits
   always_comb begin
      cRead    = 1'b0;
      cWrite   = 1'b0;
      tagWrite = 1'b0;
      dirtySet = 1'b0;
      rRead    = 1'b0;
      rWrite   = 1'b0;
      selOut   = 1'b0;
      cpu_done = 1'b0;
      busy     = (r_state != S_IDLE);
      wordIdx  = w_idx;
      unique case (r_state)
         S_LOOKUP: begin
            cRead    = 1'b1;
            selOut   = 1'b1;
            cWrite   = hit && cpu_we;
            dirtySet = hit && cpu_we && WRITE_BACK;
         end
         S_WBACK: begin
            cRead  = 1'b1;
            rWrite = 1'b1;
         end
         S_FILL: begin
            rRead    = 1'b1;
            cWrite   = mem_ack;
            tagWrite = mem_ack && w_last;
         end
         S_WTHRU: rWrite = 1'b1;
         S_DONE: begin
            cpu_done = 1'b1;
            selOut   = 1'b1;
         end
         default: ;
      endcase
   end

   // Marks the lookup that follows a fill so statistics count each request once
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_relookup <= 1'b0;
      end else if (r_state == S_FILL && mem_ack && w_last) begin
         r_relookup <= 1'b1;
      end else if (r_state == S_LOOKUP) begin
         r_relookup <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (r_state == S_LOOKUP && !r_relookup) begin
         if (hit) begin
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
         end else begin
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
         end
      end
   end

   assign hitCount  = r_hit_cnt;
   assign missCount = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Self-checking bench for cache_ctrl_fsm: write-back, write-through and
// 2-bit-counter instances sharing array/memory stimulus.
module tb_cache_ctrl_fsm;

   typedef struct {
      int hits;
      int misses;
      int wb;
      int fill;
      int ds;
      int tw;
      int cw;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cpu_we = 1'b0, hit = 1'b0, dirty = 1'b0, mem_ack = 1'b0;
   logic req_a = 1'b0, req_wt = 1'b0, req_sat = 1'b0;

   logic a_cRead, a_cWrite, a_tagWrite, a_dirtySet, a_rRead, a_rWrite, a_selOut, a_cpu_done, a_busy;
   logic [1:0] a_wordIdx;
   logic [15:0] a_hitCount, a_missCount;
   logic wt_cRead, wt_cWrite, wt_tagWrite, wt_dirtySet, wt_rRead, wt_rWrite, wt_selOut, wt_cpu_done, wt_busy;
   logic [1:0] wt_wordIdx;
   logic [15:0] wt_hitCount, wt_missCount;
   logic s_cRead, s_cWrite, s_tagWrite, s_dirtySet, s_rRead, s_rWrite, s_selOut, s_cpu_done, s_busy;
   logic [1:0] s_wordIdx;
   logic [1:0] s_hitCount, s_missCount;

   int n_checks = 0;
   int n_errors = 0;
   txn_t sb_q[$];
   int m_wb = 0, m_fill = 0, m_ds = 0, m_tw = 0, m_cw = 0;
   bit wt_ds_seen = 1'b0;

   always #5 clk = ~clk;

   cache_ctrl_fsm u_dut (
      .clk(clk), .rst(rst), .cpu_req(req_a), .cpu_we(cpu_we), .hit(hit), .dirty(dirty),
      .mem_ack(mem_ack), .cRead(a_cRead), .cWrite(a_cWrite), .tagWrite(a_tagWrite),
      .dirtySet(a_dirtySet), .rRead(a_rRead), .rWrite(a_rWrite), .selOut(a_selOut),
      .wordIdx(a_wordIdx), .cpu_done(a_cpu_done), .busy(a_busy),
      .hitCount(a_hitCount), .missCount(a_missCount)
   );

   cache_ctrl_fsm #(.WRITE_BACK(1'b0)) u_wt (
      .clk(clk), .rst(rst), .cpu_req(req_wt), .cpu_we(cpu_we), .hit(hit), .dirty(dirty),
      .mem_ack(mem_ack), .cRead(wt_cRead), .cWrite(wt_cWrite), .tagWrite(wt_tagWrite),
      .dirtySet(wt_dirtySet), .rRead(wt_rRead), .rWrite(wt_rWrite), .selOut(wt_selOut),
      .wordIdx(wt_wordIdx), .cpu_done(wt_cpu_done), .busy(wt_busy),
      .hitCount(wt_hitCount), .missCount(wt_missCount)
   );

   cache_ctrl_fsm #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .cpu_req(req_sat), .cpu_we(cpu_we), .hit(hit), .dirty(dirty),
      .mem_ack(mem_ack), .cRead(s_cRead), .cWrite(s_cWrite), .tagWrite(s_tagWrite),
      .dirtySet(s_dirtySet), .rRead(s_rRead), .rWrite(s_rWrite), .selOut(s_selOut),
      .wordIdx(s_wordIdx), .cpu_done(s_cpu_done), .busy(s_busy),
      .hitCount(s_hitCount), .missCount(s_missCount)
   );

   function automatic txn_t mk(int h, int m, int wb, int f, int ds, int tw, int cw);
      txn_t t;
      t.hits = h; t.misses = m; t.wb = wb; t.fill = f; t.ds = ds; t.tw = tw; t.cw = cw;
      return t;
   endfunction

   // Scoreboard monitor: accumulates per-request activity, checks it at cpu_done
   always @(negedge clk) begin
      txn_t e;
      #2;
      if (wt_dirtySet) wt_ds_seen = 1'b1;
      if (!rst) begin
         m_wb = 0; m_fill = 0; m_ds = 0; m_tw = 0; m_cw = 0;
      end else begin
         if (a_rWrite && mem_ack) m_wb++;
         if (a_rRead && mem_ack) m_fill++;
         if (a_dirtySet) m_ds++;
         if (a_tagWrite) m_tw++;
         if (a_cWrite) m_cw++;
         if (a_cpu_done) begin
            if (sb_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL sb_unexpected_done: got done pulse, expected none");
            end else begin
               e = sb_q.pop_front();
               n_checks++;
               if (a_hitCount !== 16'(e.hits) || a_missCount !== 16'(e.misses)) begin
                  n_errors++;
                  $display("FAIL sb_counters: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                           a_hitCount, a_missCount, e.hits, e.misses);
               end
               n_checks++;
               if (m_wb !== e.wb || m_fill !== e.fill) begin
                  n_errors++;
                  $display("FAIL sb_beats: got wb=%0d fill=%0d expected wb=%0d fill=%0d",
                           m_wb, m_fill, e.wb, e.fill);
               end
               n_checks++;
               if (m_ds !== e.ds || m_tw !== e.tw || m_cw !== e.cw) begin
                  n_errors++;
                  $display("FAIL sb_array: got ds=%0d tw=%0d cw=%0d expected ds=%0d tw=%0d cw=%0d",
                           m_ds, m_tw, m_cw, e.ds, e.tw, e.cw);
               end
            end
            m_wb = 0; m_fill = 0; m_ds = 0; m_tw = 0; m_cw = 0;
         end
      end
   end

   // Drives one request on the write-back instance; memory acks every 2nd cycle
   task automatic run_a(input bit we, input bit hit0, input bit dirty0, input int lat, input txn_t exp);
      int wb_i, f_i, ph;
      bit done;
      wb_i = 0; f_i = 0; ph = 0; done = 1'b0;
      sb_q.push_back(exp);
      @(negedge clk);
      req_a = 1'b1; cpu_we = we; hit = hit0; dirty = dirty0; mem_ack = 1'b0;
      for (int k = 0; k < 80 && !done; k++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (a_rRead) hit = 1'b1;
         if (a_rRead || a_rWrite) begin
            ph++;
            mem_ack = (ph % 2 == 0);
         end
         #1;
         if (k == 0) begin
            n_checks++;
            if (a_cRead !== 1'b1 || a_busy !== 1'b1) begin
               n_errors++;
               $display("FAIL lookup_cread: got cRead=%b busy=%b expected 1 1", a_cRead, a_busy);
            end
         end
         if (a_rWrite && mem_ack) begin
            n_checks++;
            if (a_wordIdx !== 2'(wb_i) || a_cRead !== 1'b1) begin
               n_errors++;
               $display("FAIL wback_beat: got idx=%0d cRead=%b expected idx=%0d cRead=1", a_wordIdx, a_cRead, wb_i);
            end
            wb_i++;
         end
         if (a_rRead && mem_ack) begin
            n_checks++;
            if (a_wordIdx !== 2'(f_i) || a_cWrite !== 1'b1 || a_tagWrite !== (f_i == 3) || a_selOut !== 1'b0) begin
               n_errors++;
               $display("FAIL fill_beat: got idx=%0d cWrite=%b tagWrite=%b selOut=%b expected idx=%0d 1 %b 0",
                        a_wordIdx, a_cWrite, a_tagWrite, a_selOut, f_i, (f_i == 3));
            end
            f_i++;
         end
         if (a_cpu_done) begin
            done = 1'b1;
            if (lat >= 0) begin
               n_checks++;
               if (k != lat || a_selOut !== 1'b1) begin
                  n_errors++;
                  $display("FAIL done_latency: got cycle=%0d selOut=%b expected cycle=%0d selOut=1", k, a_selOut, lat);
               end
            end
         end
      end
      req_a = 1'b0; mem_ack = 1'b0;
      if (!done) begin
         n_checks++; n_errors++;
         $display("FAIL done_timeout: got no cpu_done, expected one");
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (a_busy !== 1'b0 || a_hitCount !== 16'd0 || a_missCount !== 16'd0 || a_wordIdx !== 2'd0 ||
          a_rRead !== 1'b0 || a_rWrite !== 1'b0 || a_cpu_done !== 1'b0 || a_cRead !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_state: got busy=%b hit=%0d miss=%0d idx=%0d expected all zero",
                  a_busy, a_hitCount, a_missCount, a_wordIdx);
      end
      rst = 1'b1;
   endtask

   task automatic test_read_hit();
      run_a(1'b0, 1'b1, 1'b0, 1, mk(1, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic test_read_miss();
      run_a(1'b0, 1'b0, 1'b0, -1, mk(1, 1, 0, 4, 0, 1, 4));
   endtask

   task automatic test_write_miss_dirty();
      run_a(1'b1, 1'b0, 1'b1, -1, mk(1, 2, 4, 4, 1, 1, 5));
   endtask

   task automatic test_back_to_back();
      run_a(1'b1, 1'b1, 1'b0, 1, mk(2, 2, 0, 0, 1, 0, 1));
      run_a(1'b0, 1'b1, 1'b0, 1, mk(3, 2, 0, 0, 0, 0, 0));
   endtask

   task automatic test_write_through();
      @(negedge clk);
      req_wt = 1'b1; cpu_we = 1'b1; hit = 1'b1; dirty = 1'b0; mem_ack = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (wt_cWrite !== 1'b1 || wt_cRead !== 1'b1 || wt_rWrite !== 1'b0) begin
         n_errors++;
         $display("FAIL wt_lookup: got cWrite=%b cRead=%b rWrite=%b expected 1 1 0", wt_cWrite, wt_cRead, wt_rWrite);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         mem_ack = (c == 2);
         #1;
         n_checks++;
         if (wt_rWrite !== 1'b1 || wt_cpu_done !== 1'b0) begin
            n_errors++;
            $display("FAIL wt_hold: got rWrite=%b done=%b expected 1 0 (cycle %0d)", wt_rWrite, wt_cpu_done, c);
         end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      n_checks++;
      if (wt_cpu_done !== 1'b1 || wt_rWrite !== 1'b0 || wt_hitCount !== 16'd1) begin
         n_errors++;
         $display("FAIL wt_done: got done=%b rWrite=%b hits=%0d expected 1 0 1", wt_cpu_done, wt_rWrite, wt_hitCount);
      end
      req_wt = 1'b0;
      // Write miss without allocation: straight to memory, no fill
      @(negedge clk);
      req_wt = 1'b1; cpu_we = 1'b1; hit = 1'b0; dirty = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if (wt_cWrite !== 1'b0) begin
         n_errors++;
         $display("FAIL wt_miss_lookup: got cWrite=%b expected 0", wt_cWrite);
      end
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      n_checks++;
      if (wt_rWrite !== 1'b1 || wt_rRead !== 1'b0) begin
         n_errors++;
         $display("FAIL wt_miss_mem: got rWrite=%b rRead=%b expected 1 0", wt_rWrite, wt_rRead);
      end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      n_checks++;
      if (wt_cpu_done !== 1'b1 || wt_missCount !== 16'd1 || wt_hitCount !== 16'd1) begin
         n_errors++;
         $display("FAIL wt_miss_done: got done=%b miss=%0d hit=%0d expected 1 1 1", wt_cpu_done, wt_missCount, wt_hitCount);
      end
      req_wt = 1'b0;
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_sat = 1'b1; cpu_we = 1'b0; hit = 1'b1; dirty = 1'b0;
         @(negedge clk);
         @(negedge clk); #1;
         n_checks++;
         if (s_cpu_done !== 1'b1 || s_hitCount !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
            n_errors++;
            $display("FAIL sat_hits: got done=%b hits=%0d expected 1 %0d", s_cpu_done, s_hitCount,
                     (i + 1 > 3) ? 3 : i + 1);
         end
         req_sat = 1'b0;
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         mem_ack = 1'b1;
         #1;
         n_checks++;
         if (s_busy !== 1'b0 || s_rWrite !== 1'b0 || s_cWrite !== 1'b0 || s_wordIdx !== 2'd0 ||
             s_hitCount !== 2'd3 || s_missCount !== 2'd0) begin
            n_errors++;
            $display("FAIL stray_ack: got busy=%b rWrite=%b cWrite=%b idx=%0d hits=%0d miss=%0d expected 0 0 0 0 3 0",
                     s_busy, s_rWrite, s_cWrite, s_wordIdx, s_hitCount, s_missCount);
         end
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      int ph;
      bit hit_b2;
      ph = 0; hit_b2 = 1'b0;
      @(negedge clk);
      req_a = 1'b1; cpu_we = 1'b0; hit = 1'b0; dirty = 1'b0;
      for (int k = 0; k < 40 && !hit_b2; k++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (a_rRead) begin
            ph++;
            mem_ack = (ph % 2 == 0);
         end
         #1;
         if (a_rRead && mem_ack && a_wordIdx == 2'd1) begin
            hit_b2 = 1'b1;
            rst = 1'b0;
         end
      end
      if (!hit_b2) begin
         n_checks++; n_errors++;
         $display("FAIL mid_fill_reach: got no second fill beat, expected one");
         rst = 1'b0;
      end
      @(negedge clk);
      mem_ack = 1'b0; req_a = 1'b0;
      #1;
      n_checks++;
      if (a_rRead !== 1'b0 || a_rWrite !== 1'b0 || a_cWrite !== 1'b0 || a_tagWrite !== 1'b0 ||
          a_busy !== 1'b0 || a_cpu_done !== 1'b0 || a_wordIdx !== 2'd0 ||
          a_hitCount !== 16'd0 || a_missCount !== 16'd0) begin
         n_errors++;
         $display("FAIL mid_reset: got rRead=%b busy=%b idx=%0d hit=%0d miss=%0d expected all zero",
                  a_rRead, a_busy, a_wordIdx, a_hitCount, a_missCount);
      end
      rst = 1'b1;
      run_a(1'b0, 1'b1, 1'b0, 1, mk(1, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_read_miss();
      test_write_miss_dirty();
      test_back_to_back();
      test_write_through();
      test_saturate();
      test_reset_mid_fill();
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL sb_leftover: got %0d pending, expected 0", sb_q.size());
      end
      n_checks++;
      if (wt_ds_seen !== 1'b0) begin
         n_errors++;
         $display("FAIL wt_dirtyset: got dirtySet seen=%b, expected 0", wt_ds_seen);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
